// File: rtl/ccc_seq_pkg.sv
// rtl/ccc_seq_pkg.sv - shared types and constants for the CCC lock/reset sequencer
package ccc_seq_pkg;

  // Sequencer state; the encoding is visible to software through SEQ_STATE
  typedef enum logic [1:0] {
    SEQ_HOLD    = 2'b00,
    SEQ_QUALIFY = 2'b01,
    SEQ_RELEASE = 2'b10,
    SEQ_RUN     = 2'b11
  } seq_state_e;

  localparam int LOSS_COUNT_W           = 8;
  localparam int LOCK_STABLE_CYCLES_DEF = 1024;
  localparam int RST_STAGGER_DEF        = 16;
  localparam int QUAL_CNT_W             = 16;
  localparam int STAG_CNT_W             = 8;

  // Saturating loss counter update; a clear in the same cycle as a loss leaves one event
  function automatic logic [LOSS_COUNT_W-1:0] loss_next(
    input logic [LOSS_COUNT_W-1:0] cur,
    input logic                    inc,
    input logic                    clr
  );
    logic [LOSS_COUNT_W-1:0] res;
    res = cur;
    if (clr) begin
      res = inc ? LOSS_COUNT_W'(1) : '0;
    end else if (inc && (cur != '1)) begin
      res = cur + LOSS_COUNT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/ccc_lock_sync.sv
// rtl/ccc_lock_sync.sv - multi-flop synchroniser for the asynchronous CCC lock signal
module ccc_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain; clears with the block reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/ccc_lock_reset_seq.sv
// rtl/ccc_lock_reset_seq.sv - qualifies CCC lock and releases staggered fabric resets
module ccc_lock_reset_seq
  import ccc_seq_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int RST_STAGGER        = RST_STAGGER_DEF
) (
  input  logic                    FAB_CLK,
  input  logic                    RESET_N,
  input  logic                    FAB_LOCK,
  input  logic                    SW_RESET_REQ,
  input  logic                    LOSS_CLR,
  output logic                    FABRIC_RESET_N,
  output logic                    PERIPH_RESET_N,
  output logic                    LOCK_OK,
  output logic [LOSS_COUNT_W-1:0] LOSS_COUNT,
  output logic [1:0]              SEQ_STATE
);

  localparam logic [QUAL_CNT_W:0] QUAL_TARGET = (QUAL_CNT_W+1)'(LOCK_STABLE_CYCLES);
  localparam logic [STAG_CNT_W:0] STAG_TARGET = (STAG_CNT_W+1)'(RST_STAGGER);

  logic                    lock_s;
  seq_state_e              state_q, state_d;
  logic [QUAL_CNT_W-1:0]   qual_cnt_q, qual_cnt_d;
  logic [STAG_CNT_W-1:0]   stag_cnt_q, stag_cnt_d;
  logic [QUAL_CNT_W:0]     qual_run;
  logic [STAG_CNT_W:0]     stag_run;
  logic                    lock_loss;
  logic [LOSS_COUNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                    fabric_rst_n_q, periph_rst_n_q, lock_ok_q;

  ccc_lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (FAB_CLK),
    .rst_n(RESET_N),
    .d    (FAB_LOCK),
    .q    (lock_s)
  );

  // Run length including the current cycle; one bit wider so the compare never wraps
  assign qual_run = {1'b0, qual_cnt_q} + (QUAL_CNT_W+1)'(1);
  assign stag_run = {1'b0, stag_cnt_q} + (STAG_CNT_W+1)'(1);

  // Next-state, counter and loss-event decode; lock loss outranks a soft reset
  always_comb begin
    state_d    = state_q;
    qual_cnt_d = qual_cnt_q;
    stag_cnt_d = stag_cnt_q;
    lock_loss  = 1'b0;
    case (state_q)
      SEQ_HOLD: begin
        if (lock_s) begin
          // The HOLD cycle that sees lock already counts as the first of the run
          state_d    = SEQ_QUALIFY;
          qual_cnt_d = QUAL_CNT_W'(1);
          stag_cnt_d = '0;
        end
      end
      SEQ_QUALIFY: begin
        if (!lock_s) begin
          state_d    = SEQ_HOLD;
          qual_cnt_d = '0;
          stag_cnt_d = '0;
        end else if (qual_run >= QUAL_TARGET) begin
          state_d    = SEQ_RELEASE;
          qual_cnt_d = '0;
          stag_cnt_d = '0;
        end else begin
          qual_cnt_d = qual_run[QUAL_CNT_W-1:0];
        end
      end
      SEQ_RELEASE: begin
        if (!lock_s) begin
          lock_loss  = 1'b1;
          state_d    = SEQ_HOLD;
          qual_cnt_d = '0;
          stag_cnt_d = '0;
        end else if (SW_RESET_REQ) begin
          state_d    = SEQ_HOLD;
          qual_cnt_d = '0;
          stag_cnt_d = '0;
        end else if (stag_run >= STAG_TARGET) begin
          state_d    = SEQ_RUN;
          qual_cnt_d = '0;
          stag_cnt_d = '0;
        end else begin
          stag_cnt_d = stag_run[STAG_CNT_W-1:0];
        end
      end
      SEQ_RUN: begin
        if (!lock_s) begin
          lock_loss  = 1'b1;
          state_d    = SEQ_HOLD;
          qual_cnt_d = '0;
          stag_cnt_d = '0;
        end else if (SW_RESET_REQ) begin
          state_d    = SEQ_HOLD;
          qual_cnt_d = '0;
          stag_cnt_d = '0;
        end
      end
      default: begin
        state_d    = SEQ_HOLD;
        qual_cnt_d = '0;
        stag_cnt_d = '0;
      end
    endcase
    loss_cnt_d = loss_next(loss_cnt_q, lock_loss, LOSS_CLR);
  end

  // State, counters and registered outputs; outputs follow the next state so they switch with it
  always_ff @(posedge FAB_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= SEQ_HOLD;
      qual_cnt_q     <= '0;
      stag_cnt_q     <= '0;
      loss_cnt_q     <= '0;
      fabric_rst_n_q <= 1'b0;
      periph_rst_n_q <= 1'b0;
      lock_ok_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      qual_cnt_q     <= qual_cnt_d;
      stag_cnt_q     <= stag_cnt_d;
      loss_cnt_q     <= loss_cnt_d;
      fabric_rst_n_q <= (state_d == SEQ_RELEASE) || (state_d == SEQ_RUN);
      periph_rst_n_q <= (state_d == SEQ_RUN);
      lock_ok_q      <= (state_d == SEQ_RELEASE) || (state_d == SEQ_RUN);
    end
  end

  assign FABRIC_RESET_N = fabric_rst_n_q;
  assign PERIPH_RESET_N = periph_rst_n_q;
  assign LOCK_OK        = lock_ok_q;
  assign LOSS_COUNT     = loss_cnt_q;
  assign SEQ_STATE      = state_q;

endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// tb/tb_ccc_lock_reset_seq.sv - self-checking bench for the CCC lock/reset sequencer
module tb_ccc_lock_reset_seq;

  localparam int SYNC = 2;
  localparam int LSC  = 16;
  localparam int STAG = 4;

  logic       FAB_CLK;
  logic       RESET_N;
  logic       FAB_LOCK;
  logic       SW_RESET_REQ;
  logic       LOSS_CLR;
  logic       FABRIC_RESET_N;
  logic       PERIPH_RESET_N;
  logic       LOCK_OK;
  logic [7:0] LOSS_COUNT;
  logic [1:0] SEQ_STATE;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: m_k is the length of the current uninterrupted qualified-lock run
  int m_k    = 0;
  int m_loss = 0;
  bit m_hist[$];

  ccc_lock_reset_seq #(
    .SYNC_STAGES       (SYNC),
    .LOCK_STABLE_CYCLES(LSC),
    .RST_STAGGER       (STAG)
  ) dut (
    .FAB_CLK       (FAB_CLK),
    .RESET_N       (RESET_N),
    .FAB_LOCK      (FAB_LOCK),
    .SW_RESET_REQ  (SW_RESET_REQ),
    .LOSS_CLR      (LOSS_CLR),
    .FABRIC_RESET_N(FABRIC_RESET_N),
    .PERIPH_RESET_N(PERIPH_RESET_N),
    .LOCK_OK       (LOCK_OK),
    .LOSS_COUNT    (LOSS_COUNT),
    .SEQ_STATE     (SEQ_STATE)
  );

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_state(input int k);
    if (k == 0) return 0;
    if (k < LSC) return 1;
    if (k < LSC + STAG) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_k    = 0;
    m_loss = 0;
    m_hist = {};
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
  endtask

  task automatic model_step();
    bit ls;
    bit active;
    bit inc;
    ls     = m_hist[m_hist.size() - SYNC];
    m_hist.push_back(FAB_LOCK);
    if (m_hist.size() > 8) void'(m_hist.pop_front());
    active = (m_k >= LSC);
    inc    = 1'b0;
    if (!ls) begin
      inc = active;
      m_k = 0;
    end else if (SW_RESET_REQ && active) begin
      m_k = 0;
    end else if (m_k < LSC + STAG) begin
      m_k++;
    end
    if (LOSS_CLR) m_loss = inc ? 1 : 0;
    else if (inc && m_loss < 255) m_loss++;
  endtask

  // Model update on every edge (and on asynchronous reset) followed by a full output compare
  initial begin
    model_reset();
    @(posedge FAB_CLK);
    model_reset();
    forever begin
      #1;
      check("cyc_fabric_rst_n", FABRIC_RESET_N, (m_k >= LSC));
      check("cyc_periph_rst_n", PERIPH_RESET_N, (m_k >= LSC + STAG));
      check("cyc_lock_ok", LOCK_OK, (m_k >= LSC));
      check("cyc_loss_count", LOSS_COUNT, m_loss);
      check("cyc_seq_state", SEQ_STATE, exp_state(m_k));
      @(posedge FAB_CLK or negedge RESET_N);
      if (!RESET_N) model_reset();
      else model_step();
    end
  end

  function automatic int sig(input int sel);
    case (sel)
      0:       return int'(FABRIC_RESET_N);
      1:       return int'(PERIPH_RESET_N);
      default: return int'(SEQ_STATE);
    endcase
  endfunction

  // Counts edges until the selected output reaches val; an expired bound is reported as a failure
  task automatic wait_for(input int sel, input int val, input int max, output int n);
    n = 0;
    do begin
      @(posedge FAB_CLK);
      #1;
      n++;
    end while (sig(sel) != val && n < max);
    if (sig(sel) != val) check("wait_timeout", sig(sel), val);
  endtask

  task automatic lose_and_relock(output int drop_n, output int relock_n);
    @(negedge FAB_CLK);
    FAB_LOCK = 1'b0;
    wait_for(0, 0, 10, drop_n);
    repeat ($urandom_range(0, 3)) @(negedge FAB_CLK);
    @(negedge FAB_CLK);
    FAB_LOCK = 1'b1;
    wait_for(1, 1, 100, relock_n);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    int hi_left;
    int lo_left;
    RESET_N      = 1'b0;
    FAB_LOCK     = 1'b1;
    SW_RESET_REQ = 1'b0;
    LOSS_CLR     = 1'b0;

    // 1: reset values, then first release timing
    repeat (3) @(negedge FAB_CLK);
    check("t1_reset_fabric", FABRIC_RESET_N, 0);
    check("t1_reset_periph", PERIPH_RESET_N, 0);
    check("t1_reset_lock_ok", LOCK_OK, 0);
    check("t1_reset_loss", LOSS_COUNT, 0);
    check("t1_reset_state", SEQ_STATE, 0);
    RESET_N = 1'b1;
    wait_for(0, 1, 100, n);
    check("t1_fabric_latency", n, SYNC + LSC);
    wait_for(1, 1, 100, n);
    check("t1_periph_stagger", n, STAG);
    check("t1_lock_ok", LOCK_OK, 1);
    check("t1_state_run", SEQ_STATE, 3);

    // 2: one-cycle lock glitch during qualification restarts the window
    @(negedge FAB_CLK);
    RESET_N = 1'b0;
    @(negedge FAB_CLK);
    RESET_N = 1'b1;
    repeat (SYNC + 10) @(posedge FAB_CLK);
    @(negedge FAB_CLK);
    FAB_LOCK = 1'b0;
    @(negedge FAB_CLK);
    FAB_LOCK = 1'b1;
    wait_for(2, 0, 10, n);
    check("t2_back_to_hold", n, 2);
    check("t2_no_loss", LOSS_COUNT, 0);
    wait_for(0, 1, 100, n);
    check("t2_fresh_window", n, LSC);
    wait_for(1, 1, 100, n);
    check("t2_periph", n, STAG);

    // 4: soft reset in RUN re-sequences; soft reset in QUALIFY is ignored
    @(negedge FAB_CLK);
    SW_RESET_REQ = 1'b1;
    @(posedge FAB_CLK);
    #1;
    check("t4_sw_fabric_low", FABRIC_RESET_N, 0);
    check("t4_sw_periph_low", PERIPH_RESET_N, 0);
    check("t4_sw_state", SEQ_STATE, 0);
    check("t4_sw_no_loss", LOSS_COUNT, 0);
    @(negedge FAB_CLK);
    SW_RESET_REQ = 1'b0;
    wait_for(0, 1, 100, n);
    check("t4_rerelease_fabric", n, LSC);
    wait_for(1, 1, 100, n);
    check("t4_rerelease_periph", n, STAG);
    @(negedge FAB_CLK);
    SW_RESET_REQ = 1'b1;
    @(negedge FAB_CLK);
    SW_RESET_REQ = 1'b0;
    repeat (5) @(posedge FAB_CLK);
    @(negedge FAB_CLK);
    SW_RESET_REQ = 1'b1;
    @(posedge FAB_CLK);
    #1;
    check("t4_qualify_ignore", SEQ_STATE, 1);
    @(negedge FAB_CLK);
    SW_RESET_REQ = 1'b0;
    wait_for(0, 1, 100, n);
    check("t4_qualify_unbroken", n, LSC - 6);
    wait_for(1, 1, 100, n);

    // 3: repeated lock loss in RUN, saturating the loss counter
    for (int i = 0; i < 300; i++) begin
      lose_and_relock(n, n2);
      if (i == 0) begin
        check("t3_loss_latency", n, SYNC + 1);
      end
      check("t3_relock_sequence", n2, SYNC + LSC + STAG);
      if (i == 0) check("t3_first_loss", LOSS_COUNT, 1);
    end
    check("t3_loss_saturated", LOSS_COUNT, 255);

    // 5: clear, count to 7, then loss + soft reset + clear together
    @(negedge FAB_CLK);
    LOSS_CLR = 1'b1;
    @(negedge FAB_CLK);
    LOSS_CLR = 1'b0;
    check("t5_cleared", LOSS_COUNT, 0);
    for (int i = 0; i < 7; i++) lose_and_relock(n, n2);
    check("t5_seven", LOSS_COUNT, 7);
    @(negedge FAB_CLK);
    FAB_LOCK = 1'b0;
    @(negedge FAB_CLK);
    @(negedge FAB_CLK);
    check("t5_still_run", SEQ_STATE, 3);
    SW_RESET_REQ = 1'b1;
    LOSS_CLR     = 1'b1;
    @(negedge FAB_CLK);
    SW_RESET_REQ = 1'b0;
    LOSS_CLR     = 1'b0;
    check("t5_coincident_loss", LOSS_COUNT, 1);
    check("t5_coincident_state", SEQ_STATE, 0);

    // 6: asynchronous reset in RELEASE after two stagger cycles
    @(negedge FAB_CLK);
    FAB_LOCK = 1'b1;
    wait_for(2, 2, 100, n);
    repeat (2) @(posedge FAB_CLK);
    #1;
    check("t6_pre_state", SEQ_STATE, 2);
    #1;
    RESET_N = 1'b0;
    #1;
    check("t6_async_fabric", FABRIC_RESET_N, 0);
    check("t6_async_periph", PERIPH_RESET_N, 0);
    check("t6_async_lock_ok", LOCK_OK, 0);
    check("t6_async_loss", LOSS_COUNT, 0);
    check("t6_async_state", SEQ_STATE, 0);
    @(negedge FAB_CLK);
    RESET_N = 1'b1;
    wait_for(0, 1, 100, n);
    check("t6_restart_fabric", n, SYNC + LSC);
    wait_for(1, 1, 100, n);
    check("t6_restart_periph", n, STAG);

    // Random lock bursts with sporadic soft resets and clears, checked by the model every cycle
    hi_left = $urandom_range(5, 60);
    lo_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge FAB_CLK);
      if (hi_left > 0) begin
        FAB_LOCK = 1'b1;
        hi_left--;
        if (hi_left == 0) lo_left = $urandom_range(1, 4);
      end else begin
        FAB_LOCK = 1'b0;
        lo_left--;
        if (lo_left <= 0) hi_left = $urandom_range(5, 60);
      end
      SW_RESET_REQ = ($urandom_range(0, 49) == 0);
      LOSS_CLR     = ($urandom_range(0, 99) == 0);
    end
    @(negedge FAB_CLK);
    SW_RESET_REQ = 1'b0;
    LOSS_CLR     = 1'b0;
    repeat (3) @(negedge FAB_CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccc_lock_reset_seq.md
Name: ccc_lock_reset_seq

Overview:
Receiving end of the clock-conditioning block's lock interface. It consumes the asynchronous FAB_LOCK output of the CCC, synchronises and qualifies it over a stable-lock window, then releases two staggered fabric reset domains. It tracks lock-loss events for software. It sits directly downstream of the CCC wrapper and feeds all fabric-side reset trees.

Parameters:
SYNC_STAGES, 2, flop stages on FAB_LOCK synchroniser (legal range 2..4)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before the first release (legal range 2..65535)
RST_STAGGER, 16, cycles between FABRIC_RESET_N and PERIPH_RESET_N deassertion (legal range 1..255)

Ports:
FAB_CLK  input  1  fabric clock from the CCC; sole clock
RESET_N  input  1  asynchronous active-low reset
FAB_LOCK  input  1  CCC lock, asynchronous to FAB_CLK
SW_RESET_REQ  input  1  synchronous single-cycle soft-reset request
LOSS_CLR  input  1  synchronous pulse; clears LOSS_COUNT
FABRIC_RESET_N  output  1  first-released reset domain, active low
PERIPH_RESET_N  output  1  second-released reset domain, active low
LOCK_OK  output  1  high while state is RELEASE or RUN
LOSS_COUNT  output  8  lock-loss events, saturating at 255
SEQ_STATE  output  2  state encoding: 00 HOLD, 01 QUALIFY, 10 RELEASE, 11 RUN

Behaviour:
- Reset: one clock, FAB_CLK. RESET_N is asynchronous and active-low. On RESET_N=0 all flops clear asynchronously: FABRIC_RESET_N=0, PERIPH_RESET_N=0, LOCK_OK=0, LOSS_COUNT=0, SEQ_STATE=HOLD, synchroniser=0, counters=0. Deassertion is sampled on the next FAB_CLK edge.
- Synchroniser: lock_s is FAB_LOCK delayed by SYNC_STAGES flops. All decisions use lock_s only.
- Counters: qualify counter is 16 bits; stagger counter is 8 bits. Both clear on every state entry.
- HOLD: both resets low.
  - lock_s=1 -> QUALIFY, and that cycle counts as run-length 1.
- QUALIFY:
  - Counter increments each cycle lock_s=1.
  - lock_s=0 -> HOLD, counter cleared; no loss count.
  - When run-length reaches LOCK_STABLE_CYCLES -> RELEASE. FABRIC_RESET_N rises on that same edge.
- RELEASE:
  - FABRIC_RESET_N=1. Stagger counter counts up.
  - PERIPH_RESET_N rises, and the state moves to RUN, on the edge ending the RST_STAGGER-th RELEASE cycle.
- RUN: both resets high.
- Lock loss: lock_s=0 while in RELEASE or RUN.
  - Next edge: state -> HOLD, both resets low.
  - LOSS_COUNT increments, saturating at 255.
- Soft reset: SW_RESET_REQ=1 in RELEASE or RUN -> HOLD with both resets low, no loss count.
  - Re-qualification runs the full LOCK_STABLE_CYCLES window.
  - SW_RESET_REQ in HOLD or QUALIFY is ignored.
- Simultaneous events:
  - Lock loss and SW_RESET_REQ together: treated as a lock loss (count increments).
  - LOSS_CLR and an increment in the same cycle: LOSS_COUNT=1.
  - LOSS_CLR alone: LOSS_COUNT=0 next edge.
- Glitch rules:
  - A lock_s low of any duration, including 1 cycle, restarts qualification.
  - No filtering is applied beyond the synchroniser.
- Outputs: all are registered and glitch-free.
  - Reset outputs are never asserted combinationally from FAB_LOCK.
  - Worst-case assert latency after FAB_LOCK falls is SYNC_STAGES+1 edges.
- Reset mid-operation: RESET_N low in any state forces the HOLD values immediately. The qualify window restarts from zero after RESET_N is released.

Decomposition:
- Shared package ccc_seq_pkg holds:
  - the SEQ_STATE typedef (HOLD/QUALIFY/RELEASE/RUN, 2-bit);
  - LOSS_COUNT_W=8;
  - the default constants for LOCK_STABLE_CYCLES and RST_STAGGER.
- One sub-module, ccc_lock_sync: a parameterised SYNC_STAGES flop chain with asynchronous active-low clear. It is reused by other CCC consumers.
- The FSM, counters and loss counter stay in the top module.

Test Plan:
Bench parameters: SYNC_STAGES=2, LOCK_STABLE_CYCLES=16, RST_STAGGER=4.
1. RESET_N low, FAB_LOCK=1 -> all outputs 0, SEQ_STATE=00. Release RESET_N -> FABRIC_RESET_N rises 2+16 edges later; PERIPH_RESET_N rises 4 edges after that; LOCK_OK=1; SEQ_STATE=11.
2. FAB_LOCK toggles low for 1 cycle after 10 qualified cycles -> SEQ_STATE returns to 00, LOSS_COUNT stays 0. Release requires a fresh 16-cycle run.
3. In RUN, FAB_LOCK falls -> both resets 0 within 3 edges, LOSS_COUNT=1. Relock -> full re-sequence. Repeat 300 times -> LOSS_COUNT saturates at 255.
4. SW_RESET_REQ pulse in RUN -> resets low next edge, LOSS_COUNT unchanged, re-release after 16+4 cycles. Pulse in QUALIFY -> no effect.
5. Lock loss coincident with SW_RESET_REQ and LOSS_CLR at LOSS_COUNT=7 -> LOSS_COUNT=1, state HOLD.
6. RESET_N asserted during RELEASE (stagger count=2) -> outputs clear asynchronously without waiting for a clock edge. After release, sequence restarts from zero.
